// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register-file write arbiter
//   AW/DW    register address and data widths
//   REG_ZERO hard-wired zero register; never written, never hazards
//   wr_req_t one buffered write (destination + data)
//   hazard   true when a buffered destination collides with an address
package regfile_pkg;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam logic [AW-1:0] REG_ZERO = 5'd31;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;
    function automatic logic hazard(input logic [AW-1:0] entry, input logic [AW-1:0] a);
        return entry == a && entry != REG_ZERO;
    endfunction
endpackage

// File: rtl/wr_fifo.sv
// wr_fifo: DEPTH-entry circular FIFO of pending register writes
//   clk, reset    clock, async active-high reset (empties the FIFO)
//   push, din     enqueue din (caller guarantees !full)
//   pop           dequeue head (caller guarantees !empty)
//   head          oldest entry
//   full, empty   occupancy flags
//   valid         per-slot occupancy, for address compares
//   head_oh       one-hot slot of the head entry
//   addr          per-slot destination addresses
module wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  wr_req_t                    din,
    output wr_req_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH-1:0]           valid,
    output logic [DEPTH-1:0]           head_oh,
    output logic [DEPTH-1:0][AW-1:0]   addr
);
    localparam int PW = $clog2(DEPTH);
    wr_req_t mem [DEPTH];
    logic [PW-1:0] wp, rp, off;
    logic [PW:0] count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_comb begin
        full  = count == (PW+1)'(DEPTH);
        empty = count == '0;
        head  = mem[rp];
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // a slot is occupied when its distance from the read pointer is below count
            off        = PW'(i) - rp;
            valid[i]   = {1'b0, off} < count;
            head_oh[i] = PW'(i) == rp;
            addr[i]    = mem[i].addr;
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between ALU (port 0) and MEM (port 1)
//   clk, reset                  clock, async active-high reset
//   reqN_valid/ready/addr/data  buffered writeback request ports
//   rd_addr1, rd_addr2          decode read addresses
//   raw_stall                   a read address hits a buffered, not-issuing write
//   RegWrite/WriteRegister/WriteData  register-file write port (captured on falling edge)
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          raw_stall,
    output logic          RegWrite,
    output logic [AW-1:0] WriteRegister,
    output logic [DW-1:0] WriteData
);
    logic [1:0] push, pop, full, empty;
    logic [1:0][DEPTH-1:0] valid, head_oh;
    logic [1:0][DEPTH-1:0][AW-1:0] addr;
    wr_req_t head [2];
    wr_req_t cur;
    logic rr, sel1, issue, waw0, waw1;
    wr_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset(reset), .push(push[0]), .pop(pop[0]),
        .din(wr_req_t'{addr: req0_addr, data: req0_data}), .head(head[0]),
        .full(full[0]), .empty(empty[0]), .valid(valid[0]), .head_oh(head_oh[0]), .addr(addr[0])
    );
    wr_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .push(push[1]), .pop(pop[1]),
        .din(wr_req_t'{addr: req1_addr, data: req1_data}), .head(head[1]),
        .full(full[1]), .empty(empty[1]), .valid(valid[1]), .head_oh(head_oh[1]), .addr(addr[1])
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr <= 1'b0;
        else if (!empty[0] && !empty[1]) rr <= !rr;
    end
    always_comb begin
        // a same-cycle race on one address lets port 0 go first; otherwise each port
        // waits until the other port's older write to that address has drained
        waw0 = 1'b0;
        waw1 = req0_valid && req0_addr == req1_addr;
        for (int i = 0; i < DEPTH; i++) begin
            waw0 |= valid[1][i] && addr[1][i] == req0_addr;
            waw1 |= valid[0][i] && addr[0][i] == req1_addr;
        end
        waw0 &= req0_addr != REG_ZERO;
        waw1 &= req1_addr != REG_ZERO;
        req0_ready = !full[0] && !waw0;
        req1_ready = !full[1] && !waw1;
        push = {req1_valid && req1_ready, req0_valid && req0_ready};
        issue = !(empty[0] && empty[1]);
        sel1  = !empty[1] && (empty[0] || rr);
        pop   = {sel1, !empty[0] && !sel1};
        cur   = head[sel1];
        RegWrite      = issue && cur.addr != REG_ZERO;
        WriteRegister = issue ? cur.addr : '0;
        WriteData     = issue ? cur.data : '0;
        // the issuing head is written this cycle, so it no longer blocks decode
        raw_stall = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < DEPTH; i++)
                raw_stall |= valid[p][i] && !(pop[p] && head_oh[p][i]) &&
                             (hazard(addr[p][i], rd_addr1) || hazard(addr[p][i], rd_addr2));
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_addr, req1_addr, rd_addr1, rd_addr2, WriteRegister;
    logic [63:0] req0_data, req1_data, WriteData;
    logic        raw_stall, RegWrite;
    logic [63:0] rf [32] = '{default: '0};
    int n_asrt = 0;
    int n_fail = 0;

    regfile_wr_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .raw_stall(raw_stall),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (RegWrite) rf[WriteRegister] <= WriteData;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {req0_valid, req1_valid} = '0;
        {req0_addr, req1_addr, rd_addr1, rd_addr2} = '0;
        {req0_data, req1_data} = '0;
        #12;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wreg", WriteRegister, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_raw", raw_stall, 0);
        reset = 1'b0;
        #1;
        chk("rel_ready0", req0_ready, 1);
        chk("rel_ready1", req1_ready, 1);
        tick;
        // single write through port 0
        req0_valid = 1; req0_addr = 3; req0_data = 64'h11;
        tick;
        req0_valid = 0;
        #1;
        chk("p0_regwrite", RegWrite, 1);
        chk("p0_wreg", WriteRegister, 3);
        chk("p0_wdata", WriteData, 64'h11);
        tick;
        chk("p0_rf3", rf[3], 64'h11);
        chk("p0_idle", RegWrite, 0);
        // round robin X1,X4,X2,X5
        req0_valid = 1; req0_addr = 1; req0_data = 64'h101;
        req1_valid = 1; req1_addr = 4; req1_data = 64'h104;
        tick;
        req0_addr = 2; req0_data = 64'h102;
        req1_addr = 5; req1_data = 64'h105;
        #1;
        chk("rr_wreg_1", WriteRegister, 1);
        chk("rr_ready0", req0_ready, 1);
        chk("rr_ready1", req1_ready, 1);
        tick;
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("rr_wreg_4", WriteRegister, 4);
        chk("rr_we_4", RegWrite, 1);
        tick;
        chk("rr_wreg_2", WriteRegister, 2);
        chk("rr_we_2", RegWrite, 1);
        tick;
        chk("rr_wreg_5", WriteRegister, 5);
        chk("rr_wdata_5", WriteData, 64'h105);
        tick;
        chk("rr_done", RegWrite, 0);
        chk("rr_rf5", rf[5], 64'h105);
        // same-address race on X7
        req0_valid = 1; req0_addr = 7; req0_data = 64'hA;
        req1_valid = 1; req1_addr = 7; req1_data = 64'hB;
        #1;
        chk("waw_ready1_race", req1_ready, 0);
        chk("waw_ready0_race", req0_ready, 1);
        tick;
        req0_valid = 0;
        #1;
        chk("waw_ready1_pend", req1_ready, 0);
        chk("waw_wdata_a", WriteData, 64'hA);
        tick;
        chk("waw_ready1_free", req1_ready, 1);
        tick;
        req1_valid = 0;
        #1;
        chk("waw_wreg_b", WriteRegister, 7);
        chk("waw_wdata_b", WriteData, 64'hB);
        tick;
        chk("waw_rf7", rf[7], 64'hB);
        // reset mid-burst with two entries queued
        req0_valid = 1; req0_addr = 1; req0_data = 64'hDEAD;
        req1_valid = 1; req1_addr = 2; req1_data = 64'hBEEF;
        tick;
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("mid_regwrite", RegWrite, 1);
        chk("mid_wreg", WriteRegister, 2);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_regwrite", RegWrite, 0);
        chk("mid_rst_wreg", WriteRegister, 0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        chk("mid_after_we", RegWrite, 0);
        chk("mid_after_ready0", req0_ready, 1);
        chk("mid_after_ready1", req1_ready, 1);
        tick;
        chk("mid_after_we2", RegWrite, 0);
        chk("mid_rf1", rf[1], 64'h101);
        chk("mid_rf2", rf[2], 64'h102);
        // FIFO0 fills while round robin holds its pop
        req0_valid = 1; req0_addr = 10; req0_data = 64'h10;
        req1_valid = 1; req1_addr = 11; req1_data = 64'h11;
        tick;
        req0_addr = 12;
        req1_addr = 13;
        #1;
        chk("full_wreg_10", WriteRegister, 10);
        tick;
        req0_addr = 14;
        req1_valid = 0;
        #1;
        chk("full_wreg_11", WriteRegister, 11);
        chk("full_ready1", req1_ready, 0);
        tick;
        req0_addr = 15;
        #1;
        chk("full_ready0", req0_ready, 0);
        chk("full_wreg_12", WriteRegister, 12);
        tick;
        chk("full_ready0_free", req0_ready, 1);
        chk("full_wreg_13", WriteRegister, 13);
        tick;
        req0_valid = 0;
        #1;
        chk("full_again", req0_ready, 0);
        chk("full_wreg_14", WriteRegister, 14);
        tick;
        req0_valid = 1; req0_addr = 16;
        #1;
        chk("pp_ready0", req0_ready, 1);
        chk("pp_wreg_15", WriteRegister, 15);
        tick;
        req0_valid = 0;
        #1;
        chk("pp_ready0_kept", req0_ready, 1);
        chk("pp_wreg_16", WriteRegister, 16);
        tick;
        chk("pp_drained", RegWrite, 0);
        // RAW stall
        req0_valid = 1; req0_addr = 8; req0_data = 64'h88;
        req1_valid = 1; req1_addr = 9; req1_data = 64'h99;
        tick;
        req0_valid = 0; req1_valid = 0;
        rd_addr1 = 9;
        #1;
        chk("raw_hit1", raw_stall, 1);
        chk("raw_wreg_8", WriteRegister, 8);
        rd_addr1 = 8;
        #1;
        chk("raw_issuing", raw_stall, 0);
        rd_addr1 = 0; rd_addr2 = 9;
        #1;
        chk("raw_hit2", raw_stall, 1);
        tick;
        rd_addr1 = 9; rd_addr2 = 0;
        #1;
        chk("raw_x9_issue", raw_stall, 0);
        chk("raw_wreg_9", WriteRegister, 9);
        tick;
        req0_valid = 1; req0_addr = 31; req0_data = 64'h31;
        req1_valid = 1; req1_addr = 12; req1_data = 64'hC;
        tick;
        req0_valid = 0; req1_valid = 0;
        rd_addr1 = 0; rd_addr2 = 31;
        #1;
        chk("zero_raw", raw_stall, 0);
        chk("zero_wreg_12", WriteRegister, 12);
        tick;
        chk("zero_regwrite", RegWrite, 0);
        chk("zero_raw_issue", raw_stall, 0);
        tick;
        chk("zero_rf31", rf[31], 0);
        chk("zero_rf12", rf[12], 64'hC);
        // zero register never raises a WAW hold
        req0_valid = 1; req0_addr = 31;
        req1_valid = 1; req1_addr = 31;
        #1;
        chk("zero_waw", req1_ready, 1);
        req0_valid = 0; req1_valid = 0;
        // port 0 waits on an older port-1 write to the same register
        req1_valid = 1; req1_addr = 20; req1_data = 64'h20;
        tick;
        req1_valid = 0;
        req0_valid = 1; req0_addr = 20; req0_data = 64'h21;
        #1;
        chk("waw0_hold", req0_ready, 0);
        tick;
        chk("waw0_free", req0_ready, 1);
        tick;
        req0_valid = 0;
        #1;
        chk("waw0_wdata", WriteData, 64'h21);
        tick;
        chk("waw0_rf20", rf[20], 64'h21);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
